// File: rtl/db_pkg.sv
// Shared types and width helpers for the ping-pong double-buffer read scheduler.
package db_pkg;

  typedef enum logic {
    BANK_EMPTY = 1'b0,
    BANK_FULL  = 1'b1
  } bank_state_t;

  localparam int NUM_BANKS = 2;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/db_read_scheduler.sv
// Ping-pong bank ownership and read sequencing for the deaggregator; rd_en is combinational from sender_deq,
// memory data is valid one cycle later; sender_deq is ignored while sender_empty_n is low.
module db_read_scheduler
  import db_pkg::*;
#(
  parameter int  BANK_DEPTH = 16,
  localparam int ADDR_WIDTH = addr_width(BANK_DEPTH),
  localparam int CNT_WIDTH  = cnt_width(BANK_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  output logic                  wr_bank_sel,
  output logic                  wr_ready,
  input  logic                  wr_bank_done,
  input  logic [CNT_WIDTH-1:0]  wr_word_count,
  output logic                  sender_empty_n,
  input  logic                  sender_deq,
  output logic                  rd_en,
  output logic                  rd_bank,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_data_valid,
  output logic                  bank_released,
  output logic                  err
);

  bank_state_t           state [NUM_BANKS];
  logic [CNT_WIDTH-1:0]  cnt   [NUM_BANKS];
  logic                  wr_sel_r;
  logic                  rd_sel_r;
  logic [ADDR_WIDTH-1:0] addr_r;

  logic count_ok;
  logic write_accept;
  logic write_illegal;
  logic last_word;

  assign wr_bank_sel    = wr_sel_r;
  assign wr_ready       = (state[wr_sel_r] == BANK_EMPTY);
  assign sender_empty_n = (state[rd_sel_r] == BANK_FULL);
  assign rd_en          = sender_deq && sender_empty_n;
  assign rd_bank        = rd_sel_r;
  assign rd_addr        = addr_r;

  assign count_ok      = (wr_word_count != '0) && (wr_word_count <= CNT_WIDTH'(BANK_DEPTH));
  assign write_accept  = wr_bank_done && wr_ready && count_ok;
  assign write_illegal = wr_bank_done && !(wr_ready && count_ok);
  assign last_word     = ((CNT_WIDTH'(addr_r) + CNT_WIDTH'(1)) == cnt[rd_sel_r]);

  // Writer only ever owns an EMPTY bank and the reader a FULL one, so the
  // write and the release below never touch the same bank on one edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        state[b] <= BANK_EMPTY;
        cnt[b]   <= '0;
      end
      wr_sel_r      <= 1'b0;
      rd_sel_r      <= 1'b0;
      addr_r        <= '0;
      rd_data_valid <= 1'b0;
      bank_released <= 1'b0;
      err           <= 1'b0;
    end else if (clr) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        state[b] <= BANK_EMPTY;
        cnt[b]   <= '0;
      end
      wr_sel_r      <= 1'b0;
      rd_sel_r      <= 1'b0;
      addr_r        <= '0;
      rd_data_valid <= 1'b0;
      bank_released <= 1'b0;
      err           <= 1'b0;
    end else begin
      rd_data_valid <= rd_en;
      bank_released <= rd_en && last_word;
      if (write_illegal) begin
        err <= 1'b1;
      end
      if (write_accept) begin
        state[wr_sel_r] <= BANK_FULL;
        cnt[wr_sel_r]   <= wr_word_count;
        wr_sel_r        <= ~wr_sel_r;
      end
      if (rd_en) begin
        if (last_word) begin
          addr_r          <= '0;
          state[rd_sel_r] <= BANK_EMPTY;
          rd_sel_r        <= ~rd_sel_r;
        end else begin
          addr_r <= addr_r + ADDR_WIDTH'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_db_read_scheduler.sv
// Randomised bench for db_read_scheduler: a queue-of-filled-banks model feeds a scoreboard checked by a monitor.
module tb_db_read_scheduler;

  localparam int DEPTH = 16;

  logic       clk;
  logic       rst_n;
  logic       clr;
  logic       wr_bank_sel;
  logic       wr_ready;
  logic       wr_bank_done;
  logic [4:0] wr_word_count;
  logic       sender_empty_n;
  logic       sender_deq;
  logic       rd_en;
  logic       rd_bank;
  logic [3:0] rd_addr;
  logic       rd_data_valid;
  logic       bank_released;
  logic       err;

  db_read_scheduler #(.BANK_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr            (clr),
    .wr_bank_sel    (wr_bank_sel),
    .wr_ready       (wr_ready),
    .wr_bank_done   (wr_bank_done),
    .wr_word_count  (wr_word_count),
    .sender_empty_n (sender_empty_n),
    .sender_deq     (sender_deq),
    .rd_en          (rd_en),
    .rd_bank        (rd_bank),
    .rd_addr        (rd_addr),
    .rd_data_valid  (rd_data_valid),
    .bank_released  (bank_released),
    .err            (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: filled banks form a FIFO in write order; the reader drains the head.
  typedef struct {bit bank; int cnt;} fill_t;
  typedef struct {bit wsel; bit wrdy; bit ne; bit rde; bit rdv; bit rel; bit err;} st_t;
  typedef struct {bit bank; int addr;} rd_t;

  fill_t fq[$];
  st_t   stq[$];
  rd_t   rdq[$];
  int    m_pos;
  bit    m_wsel;
  bit    m_err;
  bit    m_prev_rd;
  bit    m_prev_last;

  int total;
  int bad;

  st_t mon_e;
  rd_t mon_r;
  int  rnd_d, rnd_w, rnd_c, rnd_k, rnd_z;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    m_pos       = 0;
    m_wsel      = 1'b0;
    m_err       = 1'b0;
    m_prev_rd   = 1'b0;
    m_prev_last = 1'b0;
  endtask

  task automatic cycle(input int deq, input int done, input int wcnt, input int c);
    st_t   e;
    rd_t   r;
    fill_t f;
    bit    last;
    @(negedge clk);
    sender_deq    = (deq != 0);
    wr_bank_done  = (done != 0);
    wr_word_count = 5'(wcnt);
    clr           = (c != 0);
    e.wsel = m_wsel;
    e.wrdy = (fq.size() < 2);
    e.ne   = (fq.size() > 0);
    e.rde  = sender_deq && e.ne;
    e.rdv  = m_prev_rd;
    e.rel  = m_prev_rd && m_prev_last;
    e.err  = m_err;
    last   = 1'b0;
    if (e.rde) begin
      r.bank = fq[0].bank;
      r.addr = m_pos;
      rdq.push_back(r);
      last = (m_pos == fq[0].cnt - 1);
    end
    stq.push_back(e);
    if (c != 0) begin
      model_reset();
    end else begin
      m_prev_rd   = e.rde;
      m_prev_last = last;
      if (e.rde) begin
        if (last) begin
          fq.delete(0);
          m_pos = 0;
        end else begin
          m_pos++;
        end
      end
      if (done != 0) begin
        if (e.wrdy && wcnt >= 1 && wcnt <= DEPTH) begin
          f.bank = m_wsel;
          f.cnt  = wcnt;
          fq.push_back(f);
          m_wsel = !m_wsel;
        end else begin
          m_err = 1'b1;
        end
      end
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_wr_ready"}, wr_ready, 1);
    chk({tag, "_wr_bank_sel"}, wr_bank_sel, 0);
    chk({tag, "_sender_empty_n"}, sender_empty_n, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, int'(rd_addr), 0);
    chk({tag, "_rd_data_valid"}, rd_data_valid, 0);
    chk({tag, "_bank_released"}, bank_released, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  // Monitor: one status record per driven cycle, plus one read record per expected rd_en.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (stq.size() > 0) begin
        mon_e = stq.pop_front();
        chk("wr_bank_sel", wr_bank_sel, mon_e.wsel);
        chk("wr_ready", wr_ready, mon_e.wrdy);
        chk("sender_empty_n", sender_empty_n, mon_e.ne);
        chk("rd_en", rd_en, mon_e.rde);
        chk("rd_data_valid", rd_data_valid, mon_e.rdv);
        chk("bank_released", bank_released, mon_e.rel);
        chk("err", err, mon_e.err);
        if (mon_e.rde) begin
          mon_r = rdq.pop_front();
          chk("rd_bank", rd_bank, mon_r.bank);
          chk("rd_addr", int'(rd_addr), mon_r.addr);
        end
      end
    end
  end

  initial begin
    total = 0;
    bad   = 0;
    model_reset();
    rst_n         = 1'b0;
    clr           = 1'b0;
    sender_deq    = 1'b1;
    wr_bank_done  = 1'b0;
    wr_word_count = '0;
    #3;
    check_reset_outputs("por");
    sender_deq = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // single bank of 4, drained by continuous deq, then one ignored deq
    cycle(0, 1, 4, 0);
    repeat (5) cycle(1, 0, 0, 0);

    // two banks back to back, no gap across the crossover
    cycle(0, 0, 0, 1);
    cycle(0, 1, 3, 0);
    cycle(0, 1, 2, 0);
    repeat (6) cycle(1, 0, 0, 0);

    // illegal writes: both banks full, count 0, count DEPTH+1
    cycle(0, 1, 4, 0);
    cycle(0, 1, 4, 0);
    cycle(0, 1, 5, 0);
    repeat (9) cycle(1, 0, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 0, 1);
    cycle(0, 1, DEPTH + 1, 0);
    cycle(0, 0, 0, 1);

    // full-depth bank and single-word bank
    cycle(0, 1, DEPTH, 0);
    cycle(0, 1, 1, 0);
    repeat (DEPTH + 2) cycle(1, 0, 0, 0);

    // last-word read and write to the other bank on the same edge
    cycle(0, 0, 0, 1);
    cycle(0, 1, 2, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 3, 0);
    repeat (4) cycle(1, 0, 0, 0);

    // asynchronous reset mid-bank
    cycle(0, 0, 0, 1);
    cycle(0, 1, DEPTH + 1, 0);
    cycle(0, 1, 5, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    @(posedge clk);
    #2;
    chk("pre_arst_rd_addr", int'(rd_addr), 2);
    chk("pre_arst_err", err, 1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("arst");
    sender_deq   = 1'b0;
    wr_bank_done = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();

    // synchronous clear mid-bank, with deq and a write in the same cycle
    cycle(0, 1, DEPTH + 1, 0);
    cycle(0, 1, 5, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 1, 3, 1);
    repeat (3) cycle(1, 0, 0, 0);

    for (int i = 0; i < 3000; i++) begin
      rnd_d = ($urandom_range(0, 9) < 7) ? 1 : 0;
      rnd_w = ($urandom_range(0, 9) < 2) ? 1 : 0;
      rnd_k = $urandom_range(0, 19);
      rnd_c = (rnd_k == 0) ? 0 : (rnd_k == 1) ? DEPTH + 1 : $urandom_range(1, DEPTH);
      rnd_z = ($urandom_range(0, 199) == 0) ? 1 : 0;
      cycle(rnd_d, rnd_w, rnd_c, rnd_z);
    end
    cycle(0, 0, 0, 0);

    @(negedge clk);
    #3;
    chk("scoreboard_drain", stq.size() + rdq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
